// File: rtl/vtj1_textbuf_pkg.sv
// vtj1_textbuf_pkg: shared constants for the text-cell buffer.
//   - register offsets relative to the bus base address
//   - CMD register bit indices
//   - fill engine state encoding
package vtj1_textbuf_pkg;

    localparam logic [7:0] REG_PTRL  = 8'd0;
    localparam logic [7:0] REG_PTRH  = 8'd1;
    localparam logic [7:0] REG_DATL  = 8'd2;
    localparam logic [7:0] REG_DATH  = 8'd3;
    localparam logic [7:0] REG_CMD   = 8'd4;
    localparam logic [7:0] REG_STAT  = 8'd5;
    localparam logic [7:0] REG_COUNT = 8'd6;

    localparam int unsigned CMD_START  = 0;
    localparam int unsigned CMD_CLRERR = 1;

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } fill_state_t;

endpackage

// File: rtl/vtj1_dpram.sv
// vtj1_dpram: simple dual-port RAM, both ports synchronous.
//   clk         clock
//   rst         async active-high reset of the read registers only
//   a_adr/a_rdt read-only port A, 1-cycle latency
//   b_adr       port B address
//   b_wen/b_wdt port B write enable / data
//   b_rdt       port B read data, 1-cycle latency
// Reads that collide with a port B write at the same address return the
// old contents. The array itself is never reset.
module vtj1_dpram #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_adr,
    output logic [DW-1:0] a_rdt,
    input  logic [AW-1:0] b_adr,
    input  logic          b_wen,
    input  logic [DW-1:0] b_wdt,
    output logic [DW-1:0] b_rdt
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (b_wen) begin
            mem[b_adr] <= b_wdt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdt <= '0;
        end else begin
            a_rdt <= mem[a_adr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdt <= '0;
        end else begin
            b_rdt <= mem[b_adr];
        end
    end

endmodule

// File: rtl/vtj1_textbuf.sv
// vtj1_textbuf: text-cell memory between the 8-bit CPU bus and vtj1_video.
//   clk, rst  clock, async active-high reset
//   adr       CPU bus address (registers at BASE..BASE+5)
//   wrt, wen  CPU bus write data / write enable
//   rdt       registered CPU read data
//   text_adr  video cell address
//   text_red  video cell data, 1-cycle latency, never stalled
//   busy      fill engine active
// Port A of the RAM belongs to video alone. Port B is shared: the fill
// engine wins, then a DATH commit, otherwise port B reads mem[ptr] into
// the readback buffer.
module vtj1_textbuf
    import vtj1_textbuf_pkg::*;
#(
    parameter int unsigned AW   = 12,
    parameter logic [7:0]  BASE = 8'h10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    adr,
    input  logic [7:0]    wrt,
    input  logic          wen,
    output logic [7:0]    rdt,
    input  logic [AW-1:0] text_adr,
    output logic [15:0]   text_red,
    output logic          busy
);

    // Bus decode
    logic [7:0] off;
    logic       hit;
    logic       wr_ptrl, wr_ptrh, wr_datl, wr_dath, wr_cmd, wr_data;

    // Offset wraps below BASE to a large value, so one compare bounds both ends.
    assign off = adr - BASE;
    assign hit = (off < REG_COUNT);

    assign wr_ptrl = wen & hit & (off == REG_PTRL);
    assign wr_ptrh = wen & hit & (off == REG_PTRH);
    assign wr_datl = wen & hit & (off == REG_DATL);
    assign wr_dath = wen & hit & (off == REG_DATH);
    assign wr_cmd  = wen & hit & (off == REG_CMD);
    assign wr_data = wr_ptrl | wr_ptrh | wr_datl | wr_dath;

    // State
    fill_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] cnt_q;
    logic [7:0]    dl_q;
    logic [7:0]    dh_q;
    logic [15:0]   rdbuf_q;
    logic          err_q;
    logic          b_rd_q;
    logic          fill_we;

    logic          start;
    logic          commit;

    // Port B
    logic          b_wen;
    logic [AW-1:0] b_adr;
    logic [15:0]   b_wdt;
    logic [15:0]   b_rdt;

    logic [15:0]   ptr_ext;
    logic [7:0]    rdt_d;

    assign start   = wr_cmd & wrt[CMD_START] & (state_q == StIdle);
    assign commit  = wr_dath & ~busy;
    assign ptr_ext = 16'(ptr_q);

    // Fill FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Fill FSM: outputs
    always_comb begin
        busy    = 1'b0;
        fill_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                fill_we = 1'b0;
            end
            StFill: begin
                busy    = 1'b1;
                fill_we = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                fill_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + AW'(1);
        end
    end

    // CPU-visible registers; data-register writes are dropped while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            dl_q  <= 8'h00;
            dh_q  <= 8'h00;
        end else if (!busy) begin
            if (wr_ptrl) begin
                ptr_q[7:0] <= wrt;
            end else if (wr_ptrh) begin
                ptr_q[AW-1:8] <= wrt[AW-9:0];
            end else if (wr_datl) begin
                dl_q <= wrt;
            end else if (wr_dath) begin
                ptr_q <= ptr_q + AW'(1);
                dh_q  <= wrt;
            end
        end
    end

    // A clear on the same write as an error-causing start wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wr_cmd && wrt[CMD_CLRERR]) begin
            err_q <= 1'b0;
        end else if (busy && (wr_data || (wr_cmd && wrt[CMD_START]))) begin
            err_q <= 1'b1;
        end
    end

    // Port B arbitration: fill, then commit, else background read of mem[ptr].
    always_comb begin
        b_wen = 1'b0;
        b_adr = ptr_q;
        b_wdt = {wrt, dl_q};
        if (fill_we) begin
            b_wen = 1'b1;
            b_adr = cnt_q;
            b_wdt = {dh_q, dl_q};
        end else if (commit) begin
            b_wen = 1'b1;
        end
    end

    // b_rd_q marks that b_rdt holds the result of an idle-cycle read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rd_q  <= 1'b0;
            rdbuf_q <= 16'h0000;
        end else begin
            b_rd_q <= ~b_wen;
            if (b_rd_q) begin
                rdbuf_q <= b_rdt;
            end
        end
    end

    // Readback mux
    always_comb begin
        rdt_d = 8'h00;
        if (hit) begin
            case (off)
                REG_PTRL: rdt_d = ptr_ext[7:0];
                REG_PTRH: rdt_d = ptr_ext[15:8];
                REG_DATL: rdt_d = rdbuf_q[7:0];
                REG_DATH: rdt_d = rdbuf_q[15:8];
                REG_STAT: rdt_d = {6'b000000, err_q, busy};
                default:  rdt_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdt <= 8'h00;
        end else begin
            rdt <= rdt_d;
        end
    end

    vtj1_dpram #(
        .AW(AW),
        .DW(16)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .a_adr(text_adr),
        .a_rdt(text_red),
        .b_adr(b_adr),
        .b_wen(b_wen),
        .b_wdt(b_wdt),
        .b_rdt(b_rdt)
    );

endmodule

// File: tb/tb_vtj1_textbuf.sv
// tb_vtj1_textbuf: scoreboard bench for vtj1_textbuf.
// Stimulus drives inputs 1 time unit after each rising edge and queues the
// expected responses; a monitor on the falling edge pops and compares.
module tb_vtj1_textbuf;

    localparam int unsigned AW   = 12;
    localparam logic [7:0]  BASE = 8'h10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    adr = 8'h00;
    logic [7:0]    wrt = 8'h00;
    logic          wen = 1'b0;
    logic [7:0]    rdt;
    logic [AW-1:0] text_adr = '0;
    logic [15:0]   text_red;
    logic          busy;

    always #5 clk = ~clk;

    vtj1_textbuf #(
        .AW  (AW),
        .BASE(BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adr     (adr),
        .wrt     (wrt),
        .wen     (wen),
        .rdt     (rdt),
        .text_adr(text_adr),
        .text_red(text_red),
        .busy    (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model and pending events handed from stimulus to the model.
    logic [15:0]   m_mem [4096];
    bit            m_val [4096];
    logic [AW-1:0] m_ptr = '0;
    logic [7:0]    m_dl = 8'h00;
    logic [7:0]    m_dh = 8'h00;
    bit            m_busy = 1'b0;
    logic [AW-1:0] m_cnt = '0;
    logic [15:0]   m_fill = 16'h0000;

    bit            pw_en = 1'b0;
    logic [AW-1:0] pw_adr = '0;
    logic [15:0]   pw_dat = 16'h0000;
    bit            fill_go = 1'b0;
    logic [15:0]   fill_val = 16'h0000;
    bit            rd_issue = 1'b0;
    bit            rd_pend = 1'b0;

    logic [15:0]   vid_exp_q [$];
    bit            vid_chk_q [$];
    logic [AW-1:0] vid_adr_q [$];
    logic [7:0]    rd_exp_q [$];
    string         rd_name_q [$];
    int            busy_q [$];

    initial begin
        for (int i = 0; i < 4096; i++) m_val[i] = 1'b0;
    end

    // Cycling video address, odd stride so every cell is visited.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            text_adr = text_adr + 12'd37;
        end
    end

    // Model: the video read at an edge sees contents before that edge's write.
    initial begin
        forever begin
            @(posedge clk);
            rd_pend = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else begin
                vid_exp_q.push_back(m_mem[text_adr]);
                vid_chk_q.push_back(m_val[text_adr]);
                vid_adr_q.push_back(text_adr);
                rd_pend = rd_issue;
                if (pw_en) begin
                    m_mem[pw_adr] = pw_dat;
                    m_val[pw_adr] = 1'b1;
                end
                if (m_busy) begin
                    m_mem[m_cnt] = m_fill;
                    m_val[m_cnt] = 1'b1;
                    if (m_cnt == 12'hFFF) m_busy = 1'b0;
                    m_cnt = m_cnt + 12'd1;
                end else if (fill_go) begin
                    m_busy = 1'b1;
                    m_cnt  = '0;
                    m_fill = fill_val;
                end
            end
        end
    end

    // Monitor
    int busy_run = 0;
    bit busy_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (vid_exp_q.size() > 0) begin
                logic [15:0]   e;
                bit            c;
                logic [AW-1:0] a;
                e = vid_exp_q.pop_front();
                c = vid_chk_q.pop_front();
                a = vid_adr_q.pop_front();
                if (!rst && c) chk($sformatf("text_red@%03h", a), text_red, e);
            end
            if (rd_pend) begin
                if (rd_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_queue: read response with no expectation");
                end else begin
                    chk(rd_name_q.pop_front(), rdt, rd_exp_q.pop_front());
                end
            end
            if (busy) begin
                busy_run++;
            end else if (busy_prev) begin
                if (busy_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_len: unexpected busy run of %0d", busy_run);
                end else begin
                    chk("busy_len", busy_run, busy_q.pop_front());
                end
                busy_run = 0;
            end
            busy_prev = busy;
        end
    end

    // Stimulus helpers, each consumes one clock.
    task automatic step();
        @(posedge clk);
        #1;
        wen      = 1'b0;
        adr      = 8'h00;
        rd_issue = 1'b0;
        pw_en    = 1'b0;
        fill_go  = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(logic [7:0] o, logic [7:0] d);
        step();
        adr = BASE + o;
        wrt = d;
        wen = 1'b1;
    endtask

    task automatic rd(logic [7:0] o, logic [7:0] exp, string name);
        step();
        adr      = BASE + o;
        rd_issue = 1'b1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
    endtask

    task automatic set_ptr(logic [11:0] p);
        wr(8'd0, p[7:0]);
        wr(8'd1, {4'h0, p[11:8]});
        m_ptr = p;
    endtask

    task automatic datl(logic [7:0] d);
        wr(8'd2, d);
        m_dl = d;
    endtask

    task automatic commit(logic [7:0] d);
        wr(8'd3, d);
        pw_en  = 1'b1;
        pw_adr = m_ptr;
        pw_dat = {d, m_dl};
        m_ptr  = m_ptr + 12'd1;
        m_dh   = d;
    endtask

    task automatic start_fill(int exp_len);
        wr(8'd4, 8'h01);
        fill_go  = 1'b1;
        fill_val = {m_dh, m_dl};
        busy_q.push_back(exp_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdt", rdt, 8'h00);
        chk("rst_text_red", text_red, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        rd(8'd0, 8'h00, "ptrl_after_rst");
        rd(8'd5, 8'h00, "stat_after_rst");
        rd(8'd4, 8'h00, "cmd_reads_zero");

        // Commit at 0x234
        set_ptr(12'h234);
        datl(8'hC1);
        commit(8'h0F);
        rd(8'd0, 8'h35, "ptrl_after_commit");
        rd(8'd1, 8'h02, "ptrh_after_commit");
        set_ptr(12'h234);
        idle(2);
        rd(8'd2, 8'hC1, "rdbuf_lo_234");
        rd(8'd3, 8'h0F, "rdbuf_hi_234");

        // Pointer wrap at 0xFFF
        set_ptr(12'hFFF);
        datl(8'hCD);
        commit(8'hAB);
        rd(8'd0, 8'h00, "ptrl_wrap");
        rd(8'd1, 8'h00, "ptrh_wrap");
        set_ptr(12'hFFF);
        idle(2);
        rd(8'd2, 8'hCD, "rdbuf_lo_fff");
        rd(8'd3, 8'hAB, "rdbuf_hi_fff");

        // Full fill with 0x0720, error handling while busy
        datl(8'h20);
        commit(8'h07);
        start_fill(4096);
        idle(10);
        wr(8'd3, 8'h55);
        rd(8'd5, 8'h03, "stat_err_busy");
        wr(8'd0, 8'h77);
        rd(8'd0, 8'h00, "ptrl_write_dropped");
        wr(8'd4, 8'h03);
        rd(8'd5, 8'h01, "stat_clear_wins");
        wr(8'd4, 8'h01);
        rd(8'd5, 8'h03, "stat_start_while_busy");
        for (int i = 0; i < 5000 && busy; i++) step();
        chk("fill_done", busy, 1'b0);
        rd(8'd5, 8'h02, "stat_after_fill");
        wr(8'd4, 8'h02);
        rd(8'd5, 8'h00, "stat_cleared");
        idle(4200);

        // Reset in the middle of a fill with 0x1E41
        set_ptr(12'h500);
        datl(8'h41);
        commit(8'h1E);
        start_fill(100);
        idle(99);
        step();
        adr = BASE + 8'd5;
        @(posedge clk);
        #1;
        chk("stat_before_rst", rdt, 8'h01);
        rst = 1'b1;
        #1;
        chk("busy_on_rst", busy, 1'b0);
        chk("rdt_on_rst", rdt, 8'h00);
        m_ptr = '0;
        m_dl  = 8'h00;
        m_dh  = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rd(8'd0, 8'h00, "ptrl_after_mid_rst");
        rd(8'd5, 8'h00, "stat_after_mid_rst");
        idle(4200);

        idle(3);
        chk("rd_queue_drained", rd_exp_q.size(), 0);
        chk("busy_queue_drained", busy_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vtj1_textbuf.md
Name: vtj1_textbuf

Overview:
Text-cell memory feeding the vtj1_video core's text port. 4096×16 dual-port RAM: port A is the video read port (text_adr in, text_red out); port B is shared by a CPU byte-register interface and a hardware fill engine. Lives between the 8-bit CPU bus and vtj1_video.

Parameters:
AW, 12, cell address width; depth = 2**AW cells.
BASE, 8'h10, bus address of register 0; registers occupy BASE..BASE+5.

Ports:
clk  in  1  system clock
rst  in  1  reset
adr  in  8  CPU bus address
wrt  in  8  CPU bus write data
wen  in  1  CPU bus write enable
rdt  out  8  CPU read data, selected by adr
text_adr  in  AW  video cell address
text_red  out  16  video cell data
busy  out  1  fill engine active

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. RAM contents are not reset.
- Reset values: rdt=0, text_red=0, busy=0. Pointer, data latches, rdbuf and err are all 0.
- Video port:
  - text_red <= mem[text_adr] every cycle, independent of rst deassertion timing.
  - Exactly 1-cycle latency. Never stalled; port B activity never delays it.
  - Read-during-write at the same address returns the old data.
- Registers (offset from BASE; write effect needs wen=1):
  - 0 PTRL: ptr[7:0] <= wrt.
  - 1 PTRH: ptr[AW-1:8] <= wrt[AW-9:0].
  - 2 DATL: dl <= wrt.
  - 3 DATH: commit mem[ptr] <= {wrt, dl}; ptr <= ptr+1.
  - 4 CMD: bit0=1 starts fill with {dh_last, dl}. bit1=1 clears err. Other bits ignored.
  - 5 STAT, read only: {6'b0, err, busy}.
- ptr arithmetic is modulo 2**AW: 4095+1 wraps to 0.
- Readback:
  - rdt is registered.
  - Offsets 0/1 read ptr bytes. Offsets 2/3 read rdbuf[7:0] / rdbuf[15:8]. Offset 4 reads 0. Offset 5 reads STAT.
  - Any other adr reads 0.
  - rdbuf <= mem[ptr] via port B on every cycle in which port B is idle. It is therefore valid 2 cycles after ptr last changed and no write is pending.
- DATH commit:
  - Uses port B in the same cycle.
  - dh_last <= wrt is retained as the fill high byte.
- Fill engine, FSM IDLE -> FILL -> IDLE:
  - On a CMD write with bit0=1 in IDLE: cnt <= 0, busy <= 1 on the next edge.
  - FILL writes mem[cnt] <= fillval, one cell per cycle, cnt increments.
  - After writing cell 2**AW-1: return to IDLE, busy <= 0. Total 4096 busy cycles.
  - ptr is not changed by the fill.
- While busy:
  - Writes to offsets 0..3 are dropped and set err (sticky).
  - A CMD start is ignored and sets err.
  - A CMD bit1 clear is honoured; if the same write also has bit0=1, the clear wins for that write.
- Simultaneous events: the fill has priority on port B; rdbuf is not refreshed during a fill.
- Reset mid-fill: the FSM goes straight to IDLE, busy=0. Cells already written keep the fill value; the rest are unchanged.
- Addresses outside BASE..BASE+5 have no effect.

Decomposition:
- Package vtj1_textbuf_pkg: register offset constants REG_PTRL..REG_STAT, CMD bit indices, FSM state encoding.
- One natural sub-module, vtj1_dpram: a generic simple dual-port RAM with a read-only port A and a read/write port B, both synchronous.

Test Plan:
- Write PTRL=8'h34, PTRH=8'h02, DATL=8'hC1, DATH=8'h0F -> mem[12'h234]=16'h0FC1; ptr reads 12'h235. Then drive text_adr=12'h234 -> text_red=16'h0FC1 one cycle later.
- Set ptr=12'hFFF, commit 16'hABCD -> ptr wraps to 12'h000. Readback at ptr=12'hFFF (offsets 2/3) after 2 idle cycles returns CD, AB.
- DATL=8'h20, DATH=8'h07, then CMD=8'h01 -> busy high for exactly 4096 cycles. Every cell, including 0 and 12'hFFF, reads 16'h0720 via text_red.
- During a fill, write DATH -> write dropped, STAT=8'h03. After the fill, STAT=8'h02. CMD=8'h02 -> STAT=8'h00.
- Assert rst at fill cycle 100 -> busy=0 and rdt=0 immediately. Cells 0..99 hold the fill value, cell 100 and up keep their old values.
- Continuous video reads of a cycling text_adr across CPU commits and a fill -> text_red always equals the model value with 1-cycle latency and no missed cycles.
